// File: rtl/asteroid_pkg.sv
// rtl/asteroid_pkg.sv - shared direction encodings, screen defaults and edge-test helper
package asteroid_pkg;

  typedef enum logic [1:0] {
    DIR_UP    = 2'd0,
    DIR_RIGHT = 2'd1,
    DIR_DOWN  = 2'd2,
    DIR_LEFT  = 2'd3
  } dir_e;

  localparam int DEF_SCREEN_W = 160;
  localparam int DEF_SCREEN_H = 120;

  // True when a one-pixel step in dir from (x,y) would leave a w x h screen.
  function automatic logic exits_screen(input int x, input int y, input dir_e dir,
                                        input int w, input int h);
    case (dir)
      DIR_UP:    return y == 0;
      DIR_RIGHT: return x == w - 1;
      DIR_DOWN:  return y == h - 1;
      default:   return x == 0;
    endcase
  endfunction

endpackage

// File: rtl/asteroid_field_if.sv
// rtl/asteroid_field_if.sv - spawn/kill/frame inputs and per-slot state outputs of the asteroid engine
interface asteroid_field_if #(
  parameter int NUM_SLOTS = 8,
  parameter int X_W       = 8,
  parameter int Y_W       = 7,
  parameter int SLOT_W    = 3
);
  logic                     frame_tick;
  logic                     spawn_req;
  logic [X_W-1:0]           spawn_x;
  logic [Y_W-1:0]           spawn_y;
  logic [1:0]               spawn_dir;
  logic                     spawn_ack;
  logic [SLOT_W-1:0]        spawn_slot;
  logic                     spawn_err;
  logic                     kill_valid;
  logic [SLOT_W-1:0]        kill_slot;
  logic [NUM_SLOTS-1:0]     active;
  logic [NUM_SLOTS*X_W-1:0] ast_x;
  logic [NUM_SLOTS*Y_W-1:0] ast_y;
  logic [NUM_SLOTS-1:0]     despawn;
  logic                     full;

  // master: scheduler/collision side; slave: the asteroid engine
  modport master (
    output frame_tick, spawn_req, spawn_x, spawn_y, spawn_dir, kill_valid, kill_slot,
    input  spawn_ack, spawn_slot, spawn_err, active, ast_x, ast_y, despawn, full
  );

  modport slave (
    input  frame_tick, spawn_req, spawn_x, spawn_y, spawn_dir, kill_valid, kill_slot,
    output spawn_ack, spawn_slot, spawn_err, active, ast_x, ast_y, despawn, full
  );
endinterface

// File: rtl/asteroid_slot.sv
// rtl/asteroid_slot.sv - one asteroid: position, direction, step divider and retire logic
module asteroid_slot
  import asteroid_pkg::*;
#(
  parameter int SCREEN_W = DEF_SCREEN_W,
  parameter int SCREEN_H = DEF_SCREEN_H,
  parameter int X_W      = 8,
  parameter int Y_W      = 7,
  parameter int MOVE_DIV = 4
) (
  input  logic           clock,
  input  logic           reset,
  input  logic           load,
  input  logic [X_W-1:0] load_x,
  input  logic [Y_W-1:0] load_y,
  input  dir_e           load_dir,
  input  logic           kill,
  input  logic           frame_tick,
  output logic           active,
  output logic [X_W-1:0] x,
  output logic [Y_W-1:0] y,
  output logic           edge_exit
);

  localparam int CNT_W = (MOVE_DIV > 1) ? $clog2(MOVE_DIV) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MOVE_DIV - 1);

  dir_e             dir;
  logic [CNT_W-1:0] cnt;

  // Inactive slots only accept loads; active slots see kill first, then motion.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      active    <= 1'b0;
      x         <= '0;
      y         <= '0;
      dir       <= DIR_UP;
      cnt       <= '0;
      edge_exit <= 1'b0;
    end else begin
      edge_exit <= 1'b0;
      if (!active) begin
        if (load) begin
          active <= 1'b1;
          x      <= load_x;
          y      <= load_y;
          dir    <= load_dir;
          cnt    <= '0;
        end
      end else if (kill) begin
        active <= 1'b0;
      end else if (frame_tick) begin
        if (cnt < CNT_MAX) begin
          cnt <= cnt + CNT_W'(1);
        end else begin
          cnt <= '0;
          if (exits_screen(int'(x), int'(y), dir, SCREEN_W, SCREEN_H)) begin
            active    <= 1'b0;
            edge_exit <= 1'b1;
          end else begin
            case (dir)
              DIR_UP:    y <= y - Y_W'(1);
              DIR_RIGHT: x <= x + X_W'(1);
              DIR_DOWN:  y <= y + Y_W'(1);
              default:   x <= x - X_W'(1);
            endcase
          end
        end
      end
    end
  end

endmodule

// File: rtl/asteroid_field.sv
// rtl/asteroid_field.sv - multi-slot asteroid engine: slot allocation, kill decode, output flattening
module asteroid_field
  import asteroid_pkg::*;
#(
  parameter int NUM_SLOTS = 8,
  parameter int SCREEN_W  = DEF_SCREEN_W,
  parameter int SCREEN_H  = DEF_SCREEN_H,
  parameter int X_W       = 8,
  parameter int Y_W       = 7,
  parameter int MOVE_DIV  = 4,
  parameter int SLOT_W    = 3
) (
  input  logic            clock,
  input  logic            reset,
  asteroid_field_if.slave bus
);

  logic [NUM_SLOTS-1:0]     active_vec;
  logic [NUM_SLOTS-1:0]     despawn_vec;
  logic [NUM_SLOTS-1:0]     load_vec;
  logic [NUM_SLOTS-1:0]     kill_vec;
  logic [NUM_SLOTS*X_W-1:0] x_vec;
  logic [NUM_SLOTS*Y_W-1:0] y_vec;
  logic [SLOT_W-1:0]        free_idx;
  logic                     found;
  logic                     in_range;
  logic                     accept;
  logic                     ack_q;
  logic                     err_q;
  logic [SLOT_W-1:0]        slot_q;

  // Lowest-index free slot, judged on registered active only.
  always_comb begin
    found    = 1'b0;
    free_idx = '0;
    for (int i = NUM_SLOTS - 1; i >= 0; i--) begin
      if (!active_vec[i]) begin
        found    = 1'b1;
        free_idx = SLOT_W'(i);
      end
    end
  end

  assign in_range = (int'(bus.spawn_x) < SCREEN_W) && (int'(bus.spawn_y) < SCREEN_H);
  assign accept   = bus.spawn_req && found && in_range;

  always_comb begin
    load_vec = '0;
    kill_vec = '0;
    for (int i = 0; i < NUM_SLOTS; i++) begin
      load_vec[i] = accept && (int'(free_idx) == i);
      kill_vec[i] = bus.kill_valid && (int'(bus.kill_slot) == i);
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      ack_q  <= 1'b0;
      err_q  <= 1'b0;
      slot_q <= '0;
    end else begin
      ack_q <= accept;
      err_q <= bus.spawn_req && !accept;
      if (accept) slot_q <= free_idx;
    end
  end

  for (genvar i = 0; i < NUM_SLOTS; i++) begin : g_slot
    asteroid_slot #(
      .SCREEN_W (SCREEN_W),
      .SCREEN_H (SCREEN_H),
      .X_W      (X_W),
      .Y_W      (Y_W),
      .MOVE_DIV (MOVE_DIV)
    ) u_slot (
      .clock      (clock),
      .reset      (reset),
      .load       (load_vec[i]),
      .load_x     (bus.spawn_x),
      .load_y     (bus.spawn_y),
      .load_dir   (dir_e'(bus.spawn_dir)),
      .kill       (kill_vec[i]),
      .frame_tick (bus.frame_tick),
      .active     (active_vec[i]),
      .x          (x_vec[i*X_W +: X_W]),
      .y          (y_vec[i*Y_W +: Y_W]),
      .edge_exit  (despawn_vec[i])
    );
  end

  assign bus.active     = active_vec;
  assign bus.despawn    = despawn_vec;
  assign bus.ast_x      = x_vec;
  assign bus.ast_y      = y_vec;
  assign bus.spawn_ack  = ack_q;
  assign bus.spawn_err  = err_q;
  assign bus.spawn_slot = slot_q;
  assign bus.full       = &active_vec;

endmodule

// File: tb/tb_asteroid_field.sv
// tb/tb_asteroid_field.sv - directed vector bench for asteroid_field at MOVE_DIV=4 and MOVE_DIV=1
module tb_asteroid_field;

  logic clock = 1'b0;
  logic reset = 1'b1;
  always #5 clock = ~clock;

  asteroid_field_if #(.NUM_SLOTS(8), .X_W(8), .Y_W(7), .SLOT_W(3)) bus4 ();
  asteroid_field_if #(.NUM_SLOTS(8), .X_W(8), .Y_W(7), .SLOT_W(3)) bus1 ();

  asteroid_field #(.NUM_SLOTS(8), .SCREEN_W(160), .SCREEN_H(120), .X_W(8), .Y_W(7),
                   .MOVE_DIV(4), .SLOT_W(3))
    dut4 (.clock(clock), .reset(reset), .bus(bus4));

  asteroid_field #(.NUM_SLOTS(8), .SCREEN_W(160), .SCREEN_H(120), .X_W(8), .Y_W(7),
                   .MOVE_DIV(1), .SLOT_W(3))
    dut1 (.clock(clock), .reset(reset), .bus(bus1));

  int n_cmp = 0;
  int n_bad = 0;

  typedef struct {
    logic tick;
    logic req;
    int   x;
    int   y;
    int   dir;
    logic kv;
    int   ks;
    logic ack;
    int   slot;
    logic err;
    int   act;
  } vec_t;

  vec_t tbl[9];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic drv4(input logic tick, input logic req, input int x, input int y, input int dir,
                      input logic kv, input int ks);
    bus4.frame_tick = tick;
    bus4.spawn_req  = req;
    bus4.spawn_x    = 8'(x);
    bus4.spawn_y    = 7'(y);
    bus4.spawn_dir  = 2'(dir);
    bus4.kill_valid = kv;
    bus4.kill_slot  = 3'(ks);
  endtask

  task automatic drv1(input logic tick, input logic req, input int x, input int y, input int dir,
                      input logic kv, input int ks);
    bus1.frame_tick = tick;
    bus1.spawn_req  = req;
    bus1.spawn_x    = 8'(x);
    bus1.spawn_y    = 7'(y);
    bus1.spawn_dir  = 2'(dir);
    bus1.kill_valid = kv;
    bus1.kill_slot  = 3'(ks);
  endtask

  task automatic idle();
    drv4(0, 0, 0, 0, 0, 0, 0);
    drv1(0, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic do_reset();
    idle();
    reset = 1'b1;
    step();
    step();
    reset = 1'b0;
  endtask

  function automatic int x_of(input logic [63:0] v, input int s);
    return int'(v[s*8 +: 8]);
  endfunction

  function automatic int y_of(input logic [55:0] v, input int s);
    return int'(v[s*7 +: 7]);
  endfunction

  initial begin
    tbl[0] = '{1'b0, 1'b1,  23,   0, 2, 1'b0, 0, 1'b1, 0, 1'b0, 8'h01};
    tbl[1] = '{1'b0, 1'b1, 160,   5, 1, 1'b0, 0, 1'b0, 0, 1'b1, 8'h01};
    tbl[2] = '{1'b0, 1'b1,  10, 120, 0, 1'b0, 0, 1'b0, 0, 1'b1, 8'h01};
    tbl[3] = '{1'b0, 1'b1,   5,   5, 3, 1'b0, 0, 1'b1, 1, 1'b0, 8'h03};
    tbl[4] = '{1'b0, 1'b0,   0,   0, 0, 1'b1, 0, 1'b0, 0, 1'b0, 8'h02};
    tbl[5] = '{1'b0, 1'b1,   7,   7, 1, 1'b0, 0, 1'b1, 0, 1'b0, 8'h03};
    tbl[6] = '{1'b0, 1'b0,   0,   0, 0, 1'b1, 4, 1'b0, 0, 1'b0, 8'h03};
    tbl[7] = '{1'b0, 1'b1,  30,  30, 2, 1'b1, 0, 1'b1, 2, 1'b0, 8'h06};
    tbl[8] = '{1'b0, 1'b0,   0,   0, 0, 1'b0, 0, 1'b0, 0, 1'b0, 8'h06};

    do_reset();
    chk("reset_active", bus4.active, 0);
    chk("reset_ack", bus4.spawn_ack, 0);
    chk("reset_slot", bus4.spawn_slot, 0);
    chk("reset_x0", x_of(bus4.ast_x, 0), 0);

    for (int i = 0; i < 9; i++) begin
      drv4(tbl[i].tick, tbl[i].req, tbl[i].x, tbl[i].y, tbl[i].dir, tbl[i].kv, tbl[i].ks);
      step();
      chk($sformatf("vec%0d_ack", i), bus4.spawn_ack, tbl[i].ack);
      chk($sformatf("vec%0d_err", i), bus4.spawn_err, tbl[i].err);
      chk($sformatf("vec%0d_active", i), bus4.active, tbl[i].act);
      chk($sformatf("vec%0d_despawn", i), bus4.despawn, 0);
      if (tbl[i].ack) chk($sformatf("vec%0d_slot", i), bus4.spawn_slot, tbl[i].slot);
    end

    // Three slots active and ticking, then an asynchronous reset mid-cycle.
    drv4(1, 1, 60, 60, 1, 0, 0);
    step();
    chk("pre_reset_active", bus4.active, 8'h07);
    drv4(1, 0, 0, 0, 0, 0, 0);
    #2 reset = 1'b1;
    #1;
    chk("async_reset_active", bus4.active, 0);
    chk("async_reset_ack", bus4.spawn_ack, 0);
    chk("async_reset_despawn", bus4.despawn, 0);
    do_reset();

    // Downward motion at MOVE_DIV=4.
    drv4(0, 1, 23, 0, 2, 0, 0);
    step();
    chk("mv_ack", bus4.spawn_ack, 1);
    chk("mv_slot", bus4.spawn_slot, 0);
    chk("mv_y0", y_of(bus4.ast_y, 0), 0);
    for (int t = 1; t <= 8; t++) begin
      drv4(1, 0, 0, 0, 0, 0, 0);
      step();
      if (t == 3) chk("mv_y_t3", y_of(bus4.ast_y, 0), 0);
      if (t == 4) chk("mv_y_t4", y_of(bus4.ast_y, 0), 1);
    end
    chk("mv_y_t8", y_of(bus4.ast_y, 0), 2);
    chk("mv_x_t8", x_of(bus4.ast_x, 0), 23);
    drv4(1, 1, 40, 50, 1, 0, 0);
    step();
    chk("spawn_tick_slot", bus4.spawn_slot, 1);
    chk("spawn_tick_x", x_of(bus4.ast_x, 1), 40);
    chk("spawn_tick_y", y_of(bus4.ast_y, 1), 50);
    do_reset();

    // Fill every slot with spawn_req held high, then overflow.
    for (int i = 0; i < 8; i++) begin
      drv4(0, 1, 1 + i, 1, 1, 0, 0);
      step();
      chk($sformatf("fill%0d_ack", i), bus4.spawn_ack, 1);
      chk($sformatf("fill%0d_slot", i), bus4.spawn_slot, i);
    end
    chk("fill_full", bus4.full, 1);
    step();
    chk("over_err", bus4.spawn_err, 1);
    chk("over_ack", bus4.spawn_ack, 0);
    chk("over_active", bus4.active, 8'hFF);
    drv4(0, 1, 9, 9, 0, 1, 5);
    step();
    chk("kill_same_cycle_err", bus4.spawn_err, 1);
    chk("kill_same_cycle_active", bus4.active, 8'hDF);
    chk("kill_full", bus4.full, 0);
    drv4(0, 1, 9, 9, 0, 0, 0);
    step();
    chk("refill_slot", bus4.spawn_slot, 5);
    chk("refill_active", bus4.active, 8'hFF);
    do_reset();

    // Edge exit and kill/exit collision at MOVE_DIV=1.
    drv1(0, 1, 159, 80, 1, 0, 0);
    step();
    chk("edge_ack", bus1.spawn_ack, 1);
    drv1(1, 0, 0, 0, 0, 0, 0);
    step();
    chk("edge_active", bus1.active, 0);
    chk("edge_despawn", bus1.despawn, 8'h01);
    chk("edge_x_hold", x_of(bus1.ast_x, 0), 159);
    drv1(0, 0, 0, 0, 0, 0, 0);
    step();
    chk("edge_despawn_once", bus1.despawn, 0);
    chk("edge_x_hold2", x_of(bus1.ast_x, 0), 159);
    drv1(0, 1, 0, 10, 3, 0, 0);
    step();
    chk("kx_ack_slot", bus1.spawn_slot, 0);
    chk("kx_active", bus1.active, 8'h01);
    drv1(1, 0, 0, 0, 0, 1, 0);
    step();
    chk("kx_killed", bus1.active, 0);
    chk("kx_no_despawn", bus1.despawn, 0);
    drv1(0, 0, 0, 0, 0, 0, 0);
    step();
    chk("kx_no_despawn2", bus1.despawn, 0);
    drv1(1, 1, 50, 50, 0, 0, 0);
    step();
    chk("st1_y_spawn", y_of(bus1.ast_y, 0), 50);
    drv1(1, 0, 0, 0, 0, 0, 0);
    step();
    chk("st1_y_step", y_of(bus1.ast_y, 0), 49);
    idle();
    step();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/asteroid_field.md
Name: asteroid_field

Overview:
- Parametrised multi-slot asteroid engine; generalises the fixed one-per-origin asteroid blocks.
- Holds NUM_SLOTS asteroids, each with a binary x/y coordinate, a direction and an active flag.
- Allocates free slots on spawn requests, steps each asteroid once every MOVE_DIV frame ticks, and retires asteroids at the screen edge or on a kill from collision logic.
- Sits between the spawn scheduler/FSM and the VGA draw/collision logic.

Parameters:
NUM_SLOTS, 8, number of asteroid slots (1..16)
SCREEN_W, 160, screen width in pixels; x range 0..SCREEN_W-1
SCREEN_H, 120, screen height in pixels; y range 0..SCREEN_H-1
X_W, 8, x coordinate width (>= clog2(SCREEN_W))
Y_W, 7, y coordinate width (>= clog2(SCREEN_H))
MOVE_DIV, 4, frame ticks per one-pixel step (>= 1)
SLOT_W, 3, slot index width (>= clog2(NUM_SLOTS), minimum 1)

Ports:
clock  in  1  system clock
reset  in  1  asynchronous, active-high reset
frame_tick  in  1  one-cycle pulse per video frame
spawn_req  in  1  request a new asteroid (level-sampled each cycle)
spawn_x  in  X_W  spawn x coordinate
spawn_y  in  Y_W  spawn y coordinate
spawn_dir  in  2  direction: 0 up (y-1), 1 right (x+1), 2 down (y+1), 3 left (x-1)
spawn_ack  out  1  registered pulse: spawn accepted
spawn_slot  out  SLOT_W  slot index used, valid with spawn_ack
spawn_err  out  1  registered pulse: rejected (field full or coordinate out of range)
kill_valid  in  1  collision logic retires a slot
kill_slot  in  SLOT_W  slot to retire
active  out  NUM_SLOTS  per-slot active flag
ast_x  out  NUM_SLOTS*X_W  flattened x; slot i at [i*X_W +: X_W]
ast_y  out  NUM_SLOTS*Y_W  flattened y; same packing
despawn  out  NUM_SLOTS  one-cycle pulse per slot retired at an edge
full  out  1  all slots active (combinational from active)

Behaviour:
- Reset (asynchronous, active-high): active=0, all coordinates=0, step counters=0, spawn_ack=spawn_err=despawn=0, spawn_slot=0. Clearing is immediate, including mid-operation.
- Spawn:
  - On a cycle with spawn_req=1, the lowest-index inactive slot is allocated. Its x, y and dir are loaded and active=1 at the next edge; step counter is cleared.
  - spawn_ack and spawn_slot assert in the same cycle the slot becomes visible (1-cycle latency).
  - No free slot, spawn_x >= SCREEN_W, or spawn_y >= SCREEN_H -> no state change; spawn_err pulses for 1 cycle.
  - Holding spawn_req high for k cycles issues k separate requests.
- Free-slot selection uses registered active only. A slot killed or despawned in the same cycle is not reusable until the next cycle.
- Motion on frame_tick, per active slot:
  - If step counter < MOVE_DIV-1, increment it.
  - Otherwise clear it and attempt a one-pixel move in dir.
  - If the move would leave the screen (x=0 and left, x=SCREEN_W-1 and right, y=0 and up, y=SCREEN_H-1 and down), the slot goes inactive, despawn[i] pulses next cycle, and the coordinates hold their last value.
- Kill: kill_valid with an active kill_slot clears active at the next edge with no despawn pulse. Kill on an inactive slot, or kill_slot >= NUM_SLOTS, is ignored.
- Simultaneous events, resolved per slot in priority order:
  - kill > despawn/move > spawn.
  - A slot spawned this cycle does not move this cycle, even if frame_tick=1.
  - Kill and edge-exit on the same slot in the same cycle: kill wins, no despawn.
- Coordinates of inactive slots are don't-care for consumers but must not change, except on spawn or reset.
- Arithmetic: unsigned, X_W/Y_W bits. Boundary checks prevent wrap-around, so x never exceeds SCREEN_W-1 and y never exceeds SCREEN_H-1.
- No combinational path from inputs to outputs except full.

Decomposition:
- Package asteroid_pkg: direction encodings DIR_UP/RIGHT/DOWN/LEFT, default SCREEN_W/SCREEN_H, edge-test helper functions.
- Sub-module asteroid_slot (one instance per slot): holds x, y, dir, active and the step counter. Inputs: load, kill, frame_tick. Outputs: state and edge_exit.
- Top level: priority encoder for free-slot allocation, kill decode, output flattening.

Test Plan:
- Reset mid-motion with 3 slots active -> active=0, despawn=0, spawn_ack=0 in the same cycle reset asserts.
- spawn_req with (23,0,dir=2), MOVE_DIV=4, 8 frame_ticks -> spawn_ack, spawn_slot=0 next cycle; y=2 after the 8th tick; x stays 23.
- Fill all 8 slots, then a 9th request -> full=1, spawn_err pulse, active unchanged. Kill slot 5, spawn again -> spawn_slot=5.
- Spawn (159,80,dir=1), MOVE_DIV=1, then 1 frame_tick -> active[0]=0, despawn[0]=1 for exactly one cycle, x holds 159.
- Kill and edge-exit on the same slot in the same cycle -> active cleared, despawn stays 0. Spawn plus frame_tick in the same cycle -> new slot coordinates equal the spawn values.
- spawn_x=160 or spawn_y=120 -> spawn_err pulse, no slot allocated.
